seg7_scan_reader: RTL and testbench
===================================

// Module: seg7_scan_reader
// PURPOSE
//  Reads a multiplexed 8-segment display bus (segments a..g,dp on bits 7..0) plus its
//  digit enables, and recovers the 4-bit digit shown on each position. It is the inverse
//  of our BCD->segment decoder and sits on the board-test/loopback path, checking what
//  the display driver actually emits. Debounces across scans and flags bad patterns.
// PARAMETERS
//  NDIG     4  number of multiplexed digit positions (digit_en width), 1..8
//  SETTLE   4  consecutive cycles digit_en must hold one value before seg_in is sampled, >=1
//  CONFIRM  2  consecutive identical samples of a position required to commit it, 1..7
// PORTS
//  clk        in   1        system clock, all logic on rising edge
//  rst_n      in   1        synchronous reset, active low
//  seg_in     in   8        segment bus {a,b,c,d,e,f,g,dp}, active high
//  digit_en   in   NDIG     digit enables, active high, legal only when one-hot
//  digits     out  4*NDIG   committed code per position; position i = digits[4i+3:4i]
//  valid      out  NDIG     position i has committed at least once since reset
//  digit_err  out  NDIG     committed code of position i is 4'hF (invalid pattern)
//  fault      out  1        sticky: fault pattern 8'h01 committed on any position
//  upd        out  1        1-cycle pulse: one or more digits/valid bits changed this cycle
// BEHAVIOUR
//  Reset: digits=all 4'hF, valid=0, digit_err=0, fault=0, upd=0, FSM=IDLE, counters=0.
//  Pattern->code (exact 8-bit match): FC->0 60->1 DA->2 F2->3 66->4 B6->5 BE->6 E0->7
//   FE->8 E6->9 01->4'hE (fault); any other value (incl. dp set on a digit)->4'hF.
//  FSM, tracked enable latched as en_q:
//   IDLE   : digit_en one-hot -> SETTLE, en_q<=digit_en, scnt<=1. Otherwise stay.
//   SETTLE : digit_en!=en_q -> if one-hot restart (en_q<=digit_en, scnt<=1) else IDLE.
//            digit_en==en_q and scnt==SETTLE -> sample seg_in at this edge, go HOLD;
//            else scnt++. So SETTLE=1 samples on the first edge seeing the new enable.
//   HOLD   : digit_en==en_q -> stay (one sample per enable period, never repeated).
//            digit_en changed -> as IDLE (one-hot -> SETTLE with scnt=1, else IDLE).
//  Zero or multi-hot digit_en never samples; it is not an error.
//  Confirm, per position i (cand[i] 4 bit, ccnt[i] 3 bit saturating at CONFIRM):
//   sample code c: c==cand[i] -> ccnt++ (sat); else cand[i]<=c, ccnt[i]<=1.
//   when the post-update ccnt==CONFIRM and (c!=digits[i] or !valid[i]): commit.
//  Commit registers on the edge after the sample edge: digits[i]<=c, valid[i]<=1,
//   digit_err[i]<=(c==4'hF), fault<=fault|(c==4'hE), upd=1 for that one cycle.
//  Re-confirming an already committed identical code: no change, no upd.
//  Only one position samples per edge, so at most one commit per cycle.
//  rst_n low mid-SETTLE/HOLD: everything returns to reset values on that edge.
//  fault clears only on reset.
// STRUCTURE
//  Shared header seg7_defs.vh (also included by the segment decoder): localparams
//   SEG_0..SEG_9, SEG_FAULT=8'h01, CODE_FAULT=4'hE, CODE_INV=4'hF, FSM state encodings.
//  Sub-module seg7_pattern_to_bcd: combinational 8-bit pattern -> 4-bit code per table.
//  Top: FSM + settle counter, one-hot check, per-position cand/ccnt arrays, output regs.
// TESTING (NDIG=4, SETTLE=4, CONFIRM=2 unless noted)
//  1 Scan en=0001,0010,0100,1000 each held 8 cycles, seg=F2,66,B6,BE, two full scans
//    -> after scan 2 digits=16'h6543, valid=4'hF, exactly 4 upd pulses, digit_err=0.
//  2 en=0001 held only 3 cycles then 0010 -> position 0 never sampled, no upd; enable
//    0011 or 0000 held 20 cycles -> no sample, FSM in IDLE.
//  3 Position 0 alternates seg FE / E6 across scans -> never commits (ccnt resets);
//    then FE twice -> digits[3:0]=8, one upd.
//  4 seg=7F twice on position 2 -> digits[11:8]=F, digit_err[2]=1; then seg=01 twice
//    -> code E, digit_err[2]=0, fault=1 and remains 1 after later valid digits.
//  5 Sweep all 10 table patterns with CONFIRM=1, SETTLE=1 -> each code committed on the
//    edge after the sample edge, upd exactly one cycle each; stable repeat -> no upd.
//  6 rst_n low for 1 cycle mid-SETTLE and after commits -> digits=FFFF, valid=0,
//    fault=0, upd=0 next cycle; next full scan recommits normally.

Source files
------------

// File: rtl/seg7_scan_reader_pkg.sv
// Shared definitions for the segment scan reader: segment patterns,
// code values, FSM states and a one-hot helper.
package seg7_scan_reader_pkg;

    localparam logic [7:0] SEG_0     = 8'hFC;
    localparam logic [7:0] SEG_1     = 8'h60;
    localparam logic [7:0] SEG_2     = 8'hDA;
    localparam logic [7:0] SEG_3     = 8'hF2;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'hB6;
    localparam logic [7:0] SEG_6     = 8'hBE;
    localparam logic [7:0] SEG_7     = 8'hE0;
    localparam logic [7:0] SEG_8     = 8'hFE;
    localparam logic [7:0] SEG_9     = 8'hE6;
    localparam logic [7:0] SEG_FAULT = 8'h01;

    localparam logic [3:0] CODE_FAULT = 4'hE;
    localparam logic [3:0] CODE_INV   = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    function automatic logic onehot8(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

endpackage

// File: rtl/seg7_pattern_to_bcd.sv
// Exact-match segment pattern to 4-bit code; anything unknown is CODE_INV.
module seg7_pattern_to_bcd
    import seg7_scan_reader_pkg::*;
(
    input  logic [7:0] pat,
    output logic [3:0] code
);

    always_comb begin
        code = CODE_INV;
        unique case (1'b1)
            (pat == SEG_0):     code = 4'd0;
            (pat == SEG_1):     code = 4'd1;
            (pat == SEG_2):     code = 4'd2;
            (pat == SEG_3):     code = 4'd3;
            (pat == SEG_4):     code = 4'd4;
            (pat == SEG_5):     code = 4'd5;
            (pat == SEG_6):     code = 4'd6;
            (pat == SEG_7):     code = 4'd7;
            (pat == SEG_8):     code = 4'd8;
            (pat == SEG_9):     code = 4'd9;
            (pat == SEG_FAULT): code = CODE_FAULT;
            default:            code = CODE_INV;
        endcase
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// Recovers the digit shown on each multiplexed display position,
// settling on each enable and confirming codes across scans.
module seg7_scan_reader
    import seg7_scan_reader_pkg::*;
#(
    parameter int NDIG    = 4,
    parameter int SETTLE  = 4,
    parameter int CONFIRM = 2
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        seg_in,
    input  logic [NDIG-1:0]   digit_en,
    output logic [4*NDIG-1:0] digits,
    output logic [NDIG-1:0]   valid,
    output logic [NDIG-1:0]   digit_err,
    output logic              fault,
    output logic              upd
);

    localparam int SW = $clog2(SETTLE + 1);
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [SW-1:0] SMAX = SW'(SETTLE);
    localparam logic [SW-1:0] SONE = SW'(1);
    localparam logic [2:0]    CMAX = 3'(CONFIRM);

    state_t            state_q;
    state_t            state_n;
    logic [NDIG-1:0]   en_q;
    logic [NDIG-1:0]   en_n;
    logic [SW-1:0]     scnt_q;
    logic [SW-1:0]     scnt_n;
    logic              sample;

    logic [7:0]        en8;
    logic              en_oh;
    logic [3:0]        code;
    logic [IW-1:0]     sidx;

    logic [3:0]        cand_q [NDIG];
    logic [2:0]        ccnt_q [NDIG];
    logic [3:0]        cur_cand;
    logic [2:0]        cur_cnt;
    logic [2:0]        ccnt_new;
    logic              commit;

    logic              pend_q;
    logic [IW-1:0]     pidx_q;
    logic [3:0]        pcode_q;

    logic [4*NDIG-1:0] digits_q;
    logic [NDIG-1:0]   valid_q;
    logic [NDIG-1:0]   derr_q;
    logic              fault_q;
    logic              upd_q;

    seg7_pattern_to_bcd u_p2b (
        .pat  (seg_in),
        .code (code)
    );

    always_comb begin
        en8 = '0;
        en8[NDIG-1:0] = digit_en;
        en_oh = onehot8(en8);
    end

    always_comb begin
        state_n = state_q;
        en_n    = en_q;
        scnt_n  = scnt_q;
        sample  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (en_oh) begin
                    state_n = ST_SETTLE;
                    en_n    = digit_en;
                    scnt_n  = SONE;
                end
            end
            ST_SETTLE: begin
                if (digit_en != en_q) begin
                    if (en_oh) begin
                        en_n   = digit_en;
                        scnt_n = SONE;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else if (scnt_q == SMAX) begin
                    sample  = 1'b1;
                    state_n = ST_HOLD;
                end else begin
                    scnt_n = scnt_q + SONE;
                end
            end
            ST_HOLD: begin
                if (digit_en != en_q) begin
                    if (en_oh) begin
                        state_n = ST_SETTLE;
                        en_n    = digit_en;
                        scnt_n  = SONE;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        sidx = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (en_q[i]) sidx = IW'(i);
        end
    end

    // A new candidate restarts the run; a repeat extends it up to CONFIRM.
    always_comb begin
        cur_cand = cand_q[sidx];
        cur_cnt  = ccnt_q[sidx];
        if (code == cur_cand) begin
            ccnt_new = (cur_cnt >= CMAX) ? CMAX : cur_cnt + 3'd1;
        end else begin
            ccnt_new = 3'd1;
        end
        commit = sample && (ccnt_new == CMAX) &&
                 ((code != digits_q[4*sidx +: 4]) || !valid_q[sidx]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            en_q     <= '0;
            scnt_q   <= '0;
            pend_q   <= 1'b0;
            pidx_q   <= '0;
            pcode_q  <= CODE_INV;
            digits_q <= {NDIG{CODE_INV}};
            valid_q  <= '0;
            derr_q   <= '0;
            fault_q  <= 1'b0;
            upd_q    <= 1'b0;
            for (int i = 0; i < NDIG; i++) begin
                cand_q[i] <= CODE_INV;
                ccnt_q[i] <= 3'd0;
            end
        end else begin
            state_q <= state_n;
            en_q    <= en_n;
            scnt_q  <= scnt_n;
            pend_q  <= commit;
            pidx_q  <= sidx;
            pcode_q <= code;
            upd_q   <= pend_q;
            if (sample) begin
                cand_q[sidx] <= code;
                ccnt_q[sidx] <= ccnt_new;
            end
            if (pend_q) begin
                digits_q[4*pidx_q +: 4] <= pcode_q;
                valid_q[pidx_q]         <= 1'b1;
                derr_q[pidx_q]          <= (pcode_q == CODE_INV);
                fault_q                 <= fault_q | (pcode_q == CODE_FAULT);
            end
        end
    end

    assign digits    = digits_q;
    assign valid     = valid_q;
    assign digit_err = derr_q;
    assign fault     = fault_q;
    assign upd       = upd_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed bench for seg7_scan_reader: default instance plus a
// SETTLE=1/CONFIRM=1 instance for the pattern sweep.
module tb_seg7_scan_reader;
    import seg7_scan_reader_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  seg_a, seg_b;
    logic [3:0]  en_a, en_b;
    logic [15:0] dig_a, dig_b;
    logic [3:0]  val_a, val_b, err_a, err_b;
    logic        flt_a, flt_b, upd_a, upd_b;

    int checks = 0;
    int errors = 0;
    int upd_cnt_a = 0;
    int upd_cnt_b = 0;

    logic [7:0] pats [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                              8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hE6};

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (upd_a) upd_cnt_a++;
        if (upd_b) upd_cnt_b++;
    end

    seg7_scan_reader #(.NDIG(4), .SETTLE(4), .CONFIRM(2)) dut (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_a), .digit_en(en_a),
        .digits(dig_a), .valid(val_a), .digit_err(err_a),
        .fault(flt_a), .upd(upd_a)
    );

    seg7_scan_reader #(.NDIG(4), .SETTLE(1), .CONFIRM(1)) d5 (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_b), .digit_en(en_b),
        .digits(dig_b), .valid(val_b), .digit_err(err_b),
        .fault(flt_b), .upd(upd_b)
    );

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_a(input logic [3:0] en, input logic [7:0] s, input int n);
        en_a  = en;
        seg_a = s;
        cyc(n);
    endtask

    task automatic pulse_a(input logic [3:0] en, input logic [7:0] s);
        drive_a(en, s, 8);
        drive_a(4'b0000, 8'h00, 2);
    endtask

    task automatic scan_a(input logic [7:0] s0, s1, s2, s3);
        drive_a(4'b0001, s0, 8);
        drive_a(4'b0010, s1, 8);
        drive_a(4'b0100, s2, 8);
        drive_a(4'b1000, s3, 8);
    endtask

    task automatic do_reset;
        en_a  = 4'b0000;
        en_b  = 4'b0000;
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        en_a = 4'b0000; seg_a = 8'h00;
        en_b = 4'b0000; seg_b = 8'h00;
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        checks++;
        if (dig_a !== 16'hFFFF) begin
            errors++; $display("FAIL reset_digits: got %h exp %h", dig_a, 16'hFFFF);
        end
        checks++;
        if (val_a !== 4'h0) begin
            errors++; $display("FAIL reset_valid: got %h exp %h", val_a, 4'h0);
        end
        checks++;
        if ({err_a, flt_a, upd_a} !== 6'b0) begin
            errors++; $display("FAIL reset_flags: got %b exp %b", {err_a, flt_a, upd_a}, 6'b0);
        end
        checks++;
        if (dig_b !== 16'hFFFF || val_b !== 4'h0) begin
            errors++; $display("FAIL reset_b: got %h/%h exp FFFF/0", dig_b, val_b);
        end
    endtask

    task automatic test_scan;
        int base;
        do_reset();
        base = upd_cnt_a;
        scan_a(8'hF2, 8'h66, 8'hB6, 8'hBE);
        checks++;
        if (val_a !== 4'h0 || dig_a !== 16'hFFFF) begin
            errors++; $display("FAIL scan1_nocommit: got %h/%h exp 0/FFFF", val_a, dig_a);
        end
        scan_a(8'hF2, 8'h66, 8'hB6, 8'hBE);
        drive_a(4'b0000, 8'h00, 3);
        checks++;
        if (dig_a !== 16'h6543) begin
            errors++; $display("FAIL scan_digits: got %h exp %h", dig_a, 16'h6543);
        end
        checks++;
        if (val_a !== 4'hF) begin
            errors++; $display("FAIL scan_valid: got %h exp %h", val_a, 4'hF);
        end
        checks++;
        if (err_a !== 4'h0 || flt_a !== 1'b0) begin
            errors++; $display("FAIL scan_err: got %h/%b exp 0/0", err_a, flt_a);
        end
        checks++;
        if (upd_cnt_a - base !== 4) begin
            errors++; $display("FAIL scan_upd: got %0d exp 4", upd_cnt_a - base);
        end
    endtask

    task automatic test_settle;
        int base;
        do_reset();
        base = upd_cnt_a;
        drive_a(4'b0001, 8'hFC, 3);
        drive_a(4'b0010, 8'hFC, 8);
        checks++;
        if (dut.ccnt_q[0] !== 3'd0) begin
            errors++; $display("FAIL settle_short: got %0d exp 0", dut.ccnt_q[0]);
        end
        checks++;
        if (dut.ccnt_q[1] !== 3'd1) begin
            errors++; $display("FAIL settle_full: got %0d exp 1", dut.ccnt_q[1]);
        end
        drive_a(4'b0011, 8'hFC, 20);
        checks++;
        if (dut.state_q !== ST_IDLE) begin
            errors++; $display("FAIL multihot_idle: got %0d exp %0d", dut.state_q, ST_IDLE);
        end
        drive_a(4'b0000, 8'hFC, 20);
        checks++;
        if (dut.state_q !== ST_IDLE) begin
            errors++; $display("FAIL zero_idle: got %0d exp %0d", dut.state_q, ST_IDLE);
        end
        checks++;
        if (upd_cnt_a - base !== 0 || val_a !== 4'h0) begin
            errors++; $display("FAIL settle_noupd: got %0d/%h exp 0/0", upd_cnt_a - base, val_a);
        end
        checks++;
        if (dut.ccnt_q[0] !== 3'd0 || dut.ccnt_q[1] !== 3'd1) begin
            errors++; $display("FAIL settle_nosample: got %0d/%0d exp 0/1", dut.ccnt_q[0], dut.ccnt_q[1]);
        end
    endtask

    task automatic test_confirm;
        int base;
        do_reset();
        base = upd_cnt_a;
        for (int k = 0; k < 4; k++) begin
            pulse_a(4'b0001, (k % 2 == 1) ? 8'hE6 : 8'hFE);
        end
        checks++;
        if (upd_cnt_a - base !== 0 || val_a !== 4'h0) begin
            errors++; $display("FAIL alt_nocommit: got %0d/%h exp 0/0", upd_cnt_a - base, val_a);
        end
        pulse_a(4'b0001, 8'hFE);
        pulse_a(4'b0001, 8'hFE);
        checks++;
        if (dig_a[3:0] !== 4'd8) begin
            errors++; $display("FAIL confirm_digit: got %h exp 8", dig_a[3:0]);
        end
        checks++;
        if (upd_cnt_a - base !== 1 || val_a !== 4'b0001) begin
            errors++; $display("FAIL confirm_upd: got %0d/%h exp 1/1", upd_cnt_a - base, val_a);
        end
    endtask

    task automatic test_invalid;
        int base;
        do_reset();
        base = upd_cnt_a;
        pulse_a(4'b0100, 8'h7F);
        pulse_a(4'b0100, 8'h7F);
        checks++;
        if (dig_a[11:8] !== 4'hF || err_a !== 4'b0100) begin
            errors++; $display("FAIL inv_code: got %h/%b exp F/0100", dig_a[11:8], err_a);
        end
        checks++;
        if (val_a !== 4'b0100 || flt_a !== 1'b0) begin
            errors++; $display("FAIL inv_valid: got %b/%b exp 0100/0", val_a, flt_a);
        end
        pulse_a(4'b0100, 8'h01);
        pulse_a(4'b0100, 8'h01);
        checks++;
        if (dig_a[11:8] !== 4'hE || err_a !== 4'b0000) begin
            errors++; $display("FAIL fault_code: got %h/%b exp E/0000", dig_a[11:8], err_a);
        end
        checks++;
        if (flt_a !== 1'b1) begin
            errors++; $display("FAIL fault_set: got %b exp 1", flt_a);
        end
        pulse_a(4'b0100, 8'hFC);
        pulse_a(4'b0100, 8'hFC);
        checks++;
        if (dig_a[11:8] !== 4'h0 || flt_a !== 1'b1) begin
            errors++; $display("FAIL fault_sticky: got %h/%b exp 0/1", dig_a[11:8], flt_a);
        end
        checks++;
        if (upd_cnt_a - base !== 3) begin
            errors++; $display("FAIL inv_upd: got %0d exp 3", upd_cnt_a - base);
        end
    endtask

    task automatic test_sweep;
        logic [3:0] prev;
        int base;
        do_reset();
        prev = 4'hF;
        for (int k = 0; k < 10; k++) begin
            en_b  = 4'b0001;
            seg_b = pats[k];
            cyc(1);
            checks++;
            if (upd_b !== 1'b0 || dig_b[3:0] !== prev) begin
                errors++; $display("FAIL sweep_latch[%0d]: got %b/%h exp 0/%h", k, upd_b, dig_b[3:0], prev);
            end
            cyc(1);
            checks++;
            if (upd_b !== 1'b0 || dig_b[3:0] !== prev) begin
                errors++; $display("FAIL sweep_sample[%0d]: got %b/%h exp 0/%h", k, upd_b, dig_b[3:0], prev);
            end
            cyc(1);
            checks++;
            if (upd_b !== 1'b1 || dig_b[3:0] !== 4'(k)) begin
                errors++; $display("FAIL sweep_commit[%0d]: got %b/%h exp 1/%h", k, upd_b, dig_b[3:0], 4'(k));
            end
            cyc(1);
            checks++;
            if (upd_b !== 1'b0) begin
                errors++; $display("FAIL sweep_pulse[%0d]: got %b exp 0", k, upd_b);
            end
            en_b = 4'b0000;
            cyc(1);
            prev = 4'(k);
        end
        base = upd_cnt_b;
        en_b  = 4'b0001;
        seg_b = 8'hE6;
        cyc(4);
        en_b = 4'b0000;
        cyc(2);
        checks++;
        if (upd_cnt_b - base !== 0 || dig_b[3:0] !== 4'd9) begin
            errors++; $display("FAIL sweep_repeat: got %0d/%h exp 0/9", upd_cnt_b - base, dig_b[3:0]);
        end
    endtask

    task automatic test_reset_mid;
        int base;
        do_reset();
        scan_a(8'hF2, 8'h66, 8'hB6, 8'h01);
        scan_a(8'hF2, 8'h66, 8'hB6, 8'h01);
        drive_a(4'b0000, 8'h00, 3);
        checks++;
        if (dig_a !== 16'hE543 || flt_a !== 1'b1) begin
            errors++; $display("FAIL pre_reset: got %h/%b exp E543/1", dig_a, flt_a);
        end
        drive_a(4'b0001, 8'hF2, 2);
        en_a  = 4'b0000;
        rst_n = 1'b0;
        cyc(1);
        checks++;
        if (dig_a !== 16'hFFFF || val_a !== 4'h0) begin
            errors++; $display("FAIL mid_reset_dig: got %h/%h exp FFFF/0", dig_a, val_a);
        end
        checks++;
        if (flt_a !== 1'b0 || upd_a !== 1'b0 || err_a !== 4'h0) begin
            errors++; $display("FAIL mid_reset_flags: got %b/%b/%h exp 0/0/0", flt_a, upd_a, err_a);
        end
        checks++;
        if (dut.state_q !== ST_IDLE) begin
            errors++; $display("FAIL mid_reset_state: got %0d exp %0d", dut.state_q, ST_IDLE);
        end
        rst_n = 1'b1;
        base = upd_cnt_a;
        scan_a(8'hF2, 8'h66, 8'hB6, 8'hBE);
        scan_a(8'hF2, 8'h66, 8'hB6, 8'hBE);
        drive_a(4'b0000, 8'h00, 3);
        checks++;
        if (dig_a !== 16'h6543 || val_a !== 4'hF) begin
            errors++; $display("FAIL recommit: got %h/%h exp 6543/F", dig_a, val_a);
        end
        checks++;
        if (upd_cnt_a - base !== 4 || flt_a !== 1'b0) begin
            errors++; $display("FAIL recommit_upd: got %0d/%b exp 4/0", upd_cnt_a - base, flt_a);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_settle();
        test_confirm();
        test_invalid();
        test_sweep();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
